// File: rtl/sprite_blit_engine.sv
// Sprite blitter: instruction FIFO, a two-state walker, and a write stage
// that lines pixel coordinates up with the one-cycle latency of the sprite ROM.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no instruction latched; pops the FIFO head when not stalled
// S_RUN  | walking the latched instruction, one element per unstalled cycle
module sprite_blit_engine #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int COORD_W     = 10,
    parameter int ID_W        = 9,
    parameter int SPRITE_DIM  = 32,
    parameter int COLOR_W     = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int TRANSPARENT = 0,
    localparam int IW         = 2*COORD_W + 3 + ID_W,
    localparam int DIM_W      = $clog2(SPRITE_DIM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IW-1:0]      instruction,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               refresh,
    output logic [ID_W-1:0]    rom_id,
    output logic [DIM_W-1:0]   rom_row,
    output logic [DIM_W-1:0]   rom_clm,
    input  logic [COLOR_W-1:0] rom_color,
    output logic               fb_we,
    output logic [COORD_W-1:0] fb_row,
    output logic [COORD_W-1:0] fb_clm,
    output logic [COLOR_W-1:0] fb_color,
    output logic               busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] OP_DRAW   = 3'd1;
    localparam logic [2:0] OP_DRAW_T = 3'd2;
    localparam logic [2:0] OP_FILL   = 3'd3;
    localparam logic [2:0] OP_CLEAR  = 3'd4;

    localparam logic [COORD_W-1:0] DIM_LAST = COORD_W'(SPRITE_DIM - 1);
    localparam logic [COORD_W-1:0] W_LAST   = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(SCREEN_H - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // instruction FIFO
    logic [IW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_next;
    logic             push, pop, has_head;
    logic [IW-1:0]    head;

    // walker
    state_t              state;
    logic [2:0]          cur_op;
    logic [ID_W-1:0]     cur_id;
    logic [COORD_W-1:0]  cur_x, cur_y;
    logic [COORD_W-1:0]  cnt_r, cnt_c;
    logic [COORD_W-1:0]  lim_r, lim_c;
    logic                op_writes, last;
    logic [COORD_W:0]    pix_r, pix_c;
    logic                pix_clip;

    // write stage
    logic               ws_valid, ws_write, ws_drawt, ws_fill, ws_clip;
    logic [COLOR_W-1:0] ws_fill_color;
    logic [COORD_W-1:0] ws_row, ws_clm;
    logic               held_valid;
    logic [COLOR_W-1:0] held_color;
    logic [COLOR_W-1:0] texel;

    assign push       = instr_valid & instr_ready;
    assign has_head   = (count != '0);
    assign head       = fifo_mem[rd_ptr];
    assign count_next = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    // Element range of the latched op; NOP and reserved codes take one silent cycle.
    always_comb begin
        lim_r     = '0;
        lim_c     = '0;
        op_writes = 1'b0;
        case (cur_op)
            OP_DRAW, OP_DRAW_T, OP_FILL: begin
                lim_r     = DIM_LAST;
                lim_c     = DIM_LAST;
                op_writes = 1'b1;
            end
            OP_CLEAR: begin
                lim_r     = H_LAST;
                lim_c     = W_LAST;
                op_writes = 1'b1;
            end
            default: ;
        endcase
    end

    assign last = (cnt_r == lim_r) && (cnt_c == lim_c);
    assign pop  = !refresh && has_head && ((state == S_IDLE) || (state == S_RUN && last));

    // Screen coordinate of the current element, one bit wider so it cannot wrap.
    assign pix_r    = (cur_op == OP_CLEAR) ? {1'b0, cnt_r} : {1'b0, cur_y} + {1'b0, cnt_r};
    assign pix_c    = (cur_op == OP_CLEAR) ? {1'b0, cnt_c} : {1'b0, cur_x} + {1'b0, cnt_c};
    assign pix_clip = (pix_r >= (COORD_W+1)'(SCREEN_H)) || (pix_c >= (COORD_W+1)'(SCREEN_W));

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            instr_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count       <= count_next;
            instr_ready <= (count_next != (PTR_W+1)'(FIFO_DEPTH));
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= instruction;
    end

    // Walker: latch the head, then step column-fastest; reload with no bubble on the last element.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cur_op <= '0;
            cur_id <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
            cnt_r  <= '0;
            cnt_c  <= '0;
        end else if (!refresh) begin
            if (pop) begin
                cur_id <= head[ID_W-1:0];
                cur_op <= head[ID_W+2:ID_W];
                cur_x  <= head[ID_W+3 +: COORD_W];
                cur_y  <= head[ID_W+3+COORD_W +: COORD_W];
                cnt_r  <= '0;
                cnt_c  <= '0;
                state  <= S_RUN;
            end else if (state == S_RUN) begin
                if (last) begin
                    state <= S_IDLE;
                end else if (cnt_c == lim_c) begin
                    cnt_c <= '0;
                    cnt_r <= cnt_r + 1'b1;
                end else begin
                    cnt_c <= cnt_c + 1'b1;
                end
            end
        end
    end

    // Write stage: captures the element presented this cycle, frozen while the scanout owns the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            ws_valid      <= 1'b0;
            ws_write      <= 1'b0;
            ws_drawt      <= 1'b0;
            ws_fill       <= 1'b0;
            ws_fill_color <= '0;
            ws_clip       <= 1'b0;
            ws_row        <= '0;
            ws_clm        <= '0;
        end else if (!refresh) begin
            ws_valid      <= (state == S_RUN);
            ws_write      <= (state == S_RUN) && op_writes;
            ws_drawt      <= (cur_op == OP_DRAW_T);
            ws_fill       <= (cur_op == OP_FILL) || (cur_op == OP_CLEAR);
            ws_fill_color <= cur_id[COLOR_W-1:0];
            ws_clip       <= pix_clip;
            ws_row        <= pix_r[COORD_W-1:0];
            ws_clm        <= pix_c[COORD_W-1:0];
        end
    end

    // The ROM keeps clocking the next address during a stall, so keep the texel of the held pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid <= 1'b0;
            held_color <= '0;
        end else if (refresh) begin
            if (!held_valid) begin
                held_color <= rom_color;
                held_valid <= 1'b1;
            end
        end else begin
            held_valid <= 1'b0;
        end
    end

    assign texel    = held_valid ? held_color : rom_color;
    assign rom_id   = cur_id;
    assign rom_row  = cnt_r[DIM_W-1:0];
    assign rom_clm  = cnt_c[DIM_W-1:0];
    assign fb_row   = ws_row;
    assign fb_clm   = ws_clm;
    assign fb_color = ws_valid ? (ws_fill ? ws_fill_color : texel) : '0;
    assign fb_we    = ws_valid && ws_write && !refresh && !rst && !ws_clip &&
                      !(ws_drawt && (texel == COLOR_W'(TRANSPARENT)));
    assign busy     = has_head || (state == S_RUN) || ws_valid;

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Directed + randomized bench for sprite_blit_engine with a pixel-list reference model.
module tb_sprite_blit_engine;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;
    localparam int ID_W     = 9;
    localparam int DIM      = 32;
    localparam int COLOR_W  = 4;
    localparam int DEPTH    = 8;
    localparam int IW       = 2*COORD_W + 3 + ID_W;
    localparam int DIM_W    = $clog2(DIM);

    logic               clk = 1'b0;
    logic               rst;
    logic [IW-1:0]      instruction;
    logic               instr_valid;
    logic               instr_ready;
    logic               refresh;
    logic [ID_W-1:0]    rom_id;
    logic [DIM_W-1:0]   rom_row, rom_clm;
    logic [COLOR_W-1:0] rom_color;
    logic               fb_we;
    logic [COORD_W-1:0] fb_row, fb_clm;
    logic [COLOR_W-1:0] fb_color;
    logic               busy;

    sprite_blit_engine dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .refresh(refresh), .rom_id(rom_id), .rom_row(rom_row),
        .rom_clm(rom_clm), .rom_color(rom_color), .fb_we(fb_we), .fb_row(fb_row),
        .fb_clm(fb_clm), .fb_color(fb_color), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rom_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int row; int clm; int color; int t;} px_t;
    px_t got[$];
    px_t exp_q[$];
    int  we_in_refresh = 0;

    function automatic int texel(input int mode, input int id, input int row, input int clm);
        if (mode == 1) return (clm % 2 == 1) ? 7 : 0;
        return (id*5 + row*3 + clm*7 + row*clm) % 16;
    endfunction

    // Sprite ROM: registered, one cycle latency.
    always @(posedge clk) rom_color <= COLOR_W'(texel(rom_mode, int'(rom_id), int'(rom_row), int'(rom_clm)));

    // Framebuffer monitor.
    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            got.push_back('{int'(fb_row), int'(fb_clm), int'(fb_color), cyc});
            if (refresh) we_in_refresh++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: expected pixel writes of one instruction, in raster order, capped at cap entries.
    task automatic model(input int op, input int x, input int y, input int id, input int mode, input int cap);
        int c;
        if (op == 1 || op == 2 || op == 3) begin
            for (int r = 0; r < DIM; r++)
                for (int k = 0; k < DIM; k++) begin
                    if (y + r < SCREEN_H && x + k < SCREEN_W && exp_q.size() < cap) begin
                        c = (op == 3) ? (id % 16) : texel(mode, id, r, k);
                        if (!(op == 2 && c == 0)) exp_q.push_back('{y + r, x + k, c, 0});
                    end
                end
        end else if (op == 4) begin
            for (int i = 0; i < SCREEN_W*SCREEN_H && i < cap; i++)
                exp_q.push_back('{i / SCREEN_W, i % SCREEN_W, id % 16, 0});
        end
    endtask

    function automatic logic [IW-1:0] mk(input int op, input int x, input int y, input int id);
        return {COORD_W'(y), COORD_W'(x), 3'(op), ID_W'(id)};
    endfunction

    task automatic push(input logic [IW-1:0] ins, output int t);
        int guard = 0;
        @(negedge clk);
        instruction = ins;
        instr_valid = 1'b1;
        while (instr_ready !== 1'b1 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) check("push_timeout", instr_ready, 1);
        @(posedge clk);
        #1;
        t = cyc;
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rand_ref, output int t_idle);
        int n = 0;
        t_idle = -1;
        while (n < budget) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                t_idle = cyc;
                break;
            end
            if (rand_ref) refresh = ($urandom_range(0, 7) == 0);
            n++;
        end
        refresh = 1'b0;
        if (t_idle < 0) check("idle_timeout", busy, 0);
    endtask

    task automatic compare_writes(input string tag);
        int bad = 0;
        int first_bad = -1;
        int n;
        check({tag, "_count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got[i].row != exp_q[i].row || got[i].clm != exp_q[i].clm || got[i].color != exp_q[i].color) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        check($sformatf("%s_pixels(first_bad=%0d)", tag, first_bad), bad, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t_idle, n_before, accepted, nbad, id, x, y, op;
        logic [IW-1:0] b2b[9];
        int b_op[9], b_x[9], b_y[9], b_id[9];
        int ops[7] = '{0, 1, 2, 3, 5, 6, 7};

        instruction = '0;
        instr_valid = 1'b0;
        refresh     = 1'b0;
        rst         = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", instr_ready, 0);
        check("rst_we", fb_we, 0);
        check("rst_busy", busy, 0);
        check("rst_fb_pos", {fb_row, fb_clm}, 0);
        check("rst_fb_color", fb_color, 0);
        check("rst_rom", {rom_id, rom_row, rom_clm}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", instr_ready, 1);

        // DRAW id=5 at origin
        got.delete(); exp_q.delete();
        model(1, 0, 0, 5, 0, 1 << 30);
        push(mk(1, 0, 0, 5), t);
        wait_idle(5000, 1'b0, t_idle);
        compare_writes("draw0");
        if (got.size() > 0) begin
            check("draw0_first_t", got[0].t, t + 2);
            check("draw0_first_pos", {got[0].row, got[0].clm}, 0);
            check("draw0_last_pos", {got[got.size()-1].row, got[got.size()-1].clm}, {32'd31, 32'd31});
        end
        check("draw0_busy_fall", t_idle, t + 2 + DIM*DIM);

        // DRAW clipped at the lower-right corner
        got.delete(); exp_q.delete();
        id = $urandom_range(0, 511);
        model(1, 620, 470, id, 0, 1 << 30);
        push(mk(1, 620, 470, id), t);
        wait_idle(5000, 1'b0, t_idle);
        compare_writes("clip");
        check("clip_writes", got.size(), 200);
        check("clip_run_len", t_idle, t + 2 + DIM*DIM);

        // DRAW_T over alternating 0/7 texels
        rom_mode = 1;
        got.delete(); exp_q.delete();
        x = $urandom_range(0, 600); y = $urandom_range(0, 440); id = $urandom_range(0, 511);
        model(2, x, y, id, 1, 1 << 30);
        push(mk(2, x, y, id), t);
        wait_idle(5000, 1'b0, t_idle);
        compare_writes("drawt");
        check("drawt_writes", got.size(), 512);
        nbad = 0;
        foreach (got[i]) if (got[i].color != 7) nbad++;
        check("drawt_color7", nbad, 0);
        rom_mode = 0;

        // REFRESH pulse of 3 cycles mid-sprite
        got.delete(); exp_q.delete(); we_in_refresh = 0;
        x = $urandom_range(0, 608); y = $urandom_range(0, 448); id = $urandom_range(0, 511);
        model(1, x, y, id, 0, 1 << 30);
        push(mk(1, x, y, id), t);
        for (int g = 0; g < 2000 && got.size() < 300; g++) begin
            @(posedge clk);
            #1;
        end
        refresh = 1'b1;
        n_before = got.size();
        repeat (3) @(posedge clk);
        #1;
        refresh = 1'b0;
        check("stall_no_writes", got.size(), n_before);
        wait_idle(5000, 1'b0, t_idle);
        compare_writes("stall");
        check("stall_we_in_refresh", we_in_refresh, 0);
        check("stall_run_len", t_idle, t + 2 + DIM*DIM + 3);

        // FIFO fill while stalled, then back-to-back execution
        got.delete(); exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            b_op[i] = ($urandom_range(0, 1) == 0) ? 1 : 3;
            b_x[i]  = $urandom_range(0, 608);
            b_y[i]  = $urandom_range(0, 448);
            b_id[i] = $urandom_range(0, 511);
            b2b[i]  = mk(b_op[i], b_x[i], b_y[i], b_id[i]);
        end
        for (int i = 0; i < 8; i++) model(b_op[i], b_x[i], b_y[i], b_id[i], 0, 1 << 30);
        @(posedge clk);
        #1;
        refresh = 1'b1;
        accepted = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            instruction = b2b[(accepted < 9) ? accepted : 8];
            instr_valid = 1'b1;
            if (instr_ready === 1'b1) accepted++;
        end
        @(negedge clk);
        check("fifo_accepted", accepted, 8);
        check("fifo_ready_full", instr_ready, 0);
        check("fifo_busy_stalled", busy, 1);
        check("fifo_no_writes_stalled", got.size(), 0);
        instr_valid = 1'b0;
        refresh = 1'b0;
        wait_idle(20000, 1'b0, t_idle);
        compare_writes("b2b");
        if (got.size() > 0) check("b2b_no_bubble", got[got.size()-1].t - got[0].t, 8*DIM*DIM - 1);

        // random mix of ops and positions with random REFRESH stalls
        got.delete(); exp_q.delete(); we_in_refresh = 0;
        for (int i = 0; i < 6; i++) begin
            op = ops[$urandom_range(0, 6)];
            x  = $urandom_range(0, 1023);
            y  = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 0) begin
                x = $urandom_range(0, 660);
                y = $urandom_range(0, 500);
            end
            id = $urandom_range(0, 511);
            model(op, x, y, id, 0, 1 << 30);
            push(mk(op, x, y, id), t);
        end
        wait_idle(30000, 1'b1, t_idle);
        compare_writes("rand");
        check("rand_we_in_refresh", we_in_refresh, 0);

        // CLEAR color 3 aborted by reset at pixel 1000, with a DRAW queued behind it
        got.delete(); exp_q.delete();
        model(4, 0, 0, 3, 0, 1000);
        push(mk(4, $urandom_range(0, 1023), $urandom_range(0, 1023), 3), t);
        push(mk(1, 0, 0, 9), t);
        for (int g = 0; g < 5000 && got.size() < 1000; g++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_in_rst_cycle", instr_ready, 0);
        @(negedge clk);
        check("abort_ready", instr_ready, 1);
        check("abort_busy", busy, 0);
        repeat (20) @(negedge clk);
        compare_writes("clear_abort");
        check("abort_busy_later", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_blit_engine.md
# sprite_blit_engine

Parametrised successor to the single-sprite graphics datapath. It accepts packed draw instructions through a valid/ready FIFO and walks each sprite with a counter-driven state machine. Pixels are fetched from a synchronous sprite ROM, clipped, and written to the pixel array write port at one pixel per cycle. All blitting pauses while the scanout owns the frame (REFRESH high).

## Interface
Parameters:
- SCREEN_W, 640: visible columns; writes at column ≥ SCREEN_W are clipped.
- SCREEN_H, 480: visible rows; writes at row ≥ SCREEN_H are clipped.
- COORD_W, 10: width of X/Y coordinates and of FB_ROW/FB_CLM.
- ID_W, 9: sprite ID width.
- SPRITE_DIM, 32: sprite edge length in pixels (power of 2); sprites are square.
- COLOR_W, 4: pixel color width.
- FIFO_DEPTH, 8: instruction FIFO entries (power of 2, ≥ 2).
- TRANSPARENT, 0: color value skipped by DRAW_T.

Ports (IW = 2·COORD_W+3+ID_W):
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous and active-high.
- INSTRUCTION  in  IW  packed instruction: {Y, X, OP[2:0], ID}.
- INSTR_VALID  in  1  instruction offered.
- INSTR_READY  out  1  FIFO not full; transfer when VALID&READY at a rising edge.
- REFRESH  in  1  scanout active; blitter stalls.
- ROM_ID  out  ID_W  sprite selected.
- ROM_ROW, ROM_CLM  out  log2(SPRITE_DIM) each  sprite texel address.
- ROM_COLOR  in  COLOR_W  texel; registered ROM, valid 1 cycle after address.
- FB_WE  out  1  pixel write strobe.
- FB_ROW, FB_CLM  out  COORD_W each  write coordinates.
- FB_COLOR  out  COLOR_W  write data.
- BUSY  out  1  FIFO non-empty, FSM not IDLE, or write stage valid.

## Operation
- OP decode:
  - 000 NOP: consumed, no writes.
  - 001 DRAW: writes SPRITE_DIM² texels at (Y+r, X+c).
  - 010 DRAW_T: as DRAW, but texels equal to TRANSPARENT are not written.
  - 011 FILL: writes a SPRITE_DIM² block at (X,Y) in color ID[COLOR_W-1:0].
  - 100 CLEAR: writes every screen pixel, SCREEN_H×SCREEN_W, in color ID[COLOR_W-1:0].
  - 101–111: treated as NOP.
- FSM states:
  - IDLE: on FIFO non-empty, pop the head, latch it, zero the r/c counters, go to RUN.
  - RUN: each unstalled cycle, present (r,c) and advance the counters, column-fastest. On the last element, if the FIFO is non-empty, pop and restart RUN with zero bubble; otherwise go to IDLE.
- Write stage: one register stage aligned to ROM latency. It carries the coordinates, op, and valid bit. FB_WE = valid & !REFRESH & !clipped & !(DRAW_T & ROM_COLOR==TRANSPARENT).
- Arithmetic:
  - Y+r and X+c are computed in COORD_W+1 bits; there is no wrap-around.
  - Clipped pixels still consume their cycle.
  - CLEAR counters span COORD_W bits and never exceed SCREEN_W-1 / SCREEN_H-1.
- FIFO: push and pop in the same cycle leave the count unchanged. No push when full (READY low). A pop on empty cannot occur.

## Timing
- Reset values: INSTR_READY=0 while RST high, 1 the cycle after. FB_WE=0, FB_ROW/FB_CLM/FB_COLOR=0, ROM_ID/ROM_ROW/ROM_CLM=0, BUSY=0. FIFO is empty and the FSM is in IDLE.
- Latency: instruction accepted at edge t0 into an empty, idle block is popped at t1. The first ROM address is presented after t1, and the first FB_WE is high in the cycle after t2.
- Throughput:
  - 1 pixel/cycle.
  - A sprite occupies exactly SPRITE_DIM² unstalled RUN cycles.
  - Back-to-back instructions have no idle cycle.
- REFRESH stall:
  - While high, counters, ROM address and write stage all hold, and FB_WE=0.
  - The held pixel is written in the first cycle REFRESH is low.
  - The FIFO still accepts instructions.
- RST mid-instruction: the instruction is aborted, any in-flight pixel is not written, and queued instructions are discarded.
- BUSY falls the cycle after the final write with the FIFO empty.

## Test plan
- Reset, then DRAW id=5 at X=0,Y=0 (SPRITE_DIM=32, REFRESH=0) -> 1024 FB_WE pulses; first on (0,0) two edges after acceptance, last on (31,31); BUSY low afterward.
- DRAW at X=620,Y=470 -> only columns 620–639 and rows 470–479 written (200 writes); run still lasts 1024 cycles.
- DRAW_T over a ROM with alternating texels 0/7 -> exactly 512 writes, all color 7.
- Push 9 instructions with VALID held high while the engine is stalled by REFRESH=1 -> READY drops after 8 pushes; on REFRESH=0 all 8 execute in order with zero bubbles between sprites.
- REFRESH pulsed for 3 cycles mid-sprite -> no FB_WE during the pulse; the pending pixel is written unchanged afterward; total writes are still 1024.
- CLEAR color 3 with RST asserted at pixel 1000 -> writes stop immediately; BUSY=0 and INSTR_READY=1 one cycle after RST falls.
